// File: rtl/seg7_pkg.sv
// Shared constants for the scanned 7-segment driver: blank pattern, hex
// segment table (bit order 0..6, active-low) and a sizing helper.
package seg7_pkg;

    localparam logic [0:6] SEG_BLANK = 7'b1111111;

    localparam logic [0:6] HEX_SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low segment pattern decoder.
module hex7seg
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [0:6] seg
);

    assign seg = HEX_SEG[nib];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver with double-buffered
// value, leading-zero/mask blanking, decimal points and a per-slot guard blank.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 50000,
    parameter int GUARD      = 500,
    parameter int LZB        = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [0:6]              display,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   anode_n,
    output logic                    frame_done
);

    localparam int CW = (clog2(DIV) < 1) ? 1 : clog2(DIV);
    localparam int IW = (clog2(NUM_DIGITS) < 1) ? 1 : clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] pend_val, act_val;
    logic [NUM_DIGITS-1:0]   pend_dp, act_dp;
    logic [NUM_DIGITS-1:0]   pend_blank, act_blank;
    logic                    pend_valid;

    logic                    tick, wrap;
    logic [3:0]              nib;
    logic [0:6]              seg;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [NUM_DIGITS-1:0]   sel;
    logic                    upper_zero;
    logic                    in_guard;
    logic                    dig_blank;
    logic                    dig_dp;

    assign tick = (cnt == CNT_MAX);
    assign wrap = tick && (idx == IDX_MAX);

    always_comb begin
        nib        = act_val[int'(idx)*4 +: 4];
        lz_blank   = '0;
        sel        = '0;
        upper_zero = 1'b1;
        // A digit is a leading zero only if it and every digit above it is zero.
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_zero  = upper_zero && (act_val[4*i +: 4] == 4'h0);
            lz_blank[i] = (LZB != 0) && upper_zero && (i != 0);
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            sel[i] = (int'(idx) == i);
        end
        in_guard  = int'(cnt) < GUARD;
        dig_blank = act_blank[idx] | lz_blank[idx];
        dig_dp    = act_dp[idx];
    end

    hex7seg u_dec (
        .nib (nib),
        .seg (seg)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            idx        <= '0;
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            pend_valid <= 1'b0;
            act_val    <= '0;
            act_dp     <= '0;
            act_blank  <= '0;
            display    <= SEG_BLANK;
            dp_n       <= 1'b1;
            anode_n    <= '1;
            frame_done <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
            end
            frame_done <= wrap;

            if (wrap && pend_valid) begin
                act_val    <= pend_val;
                act_dp     <= pend_dp;
                act_blank  <= pend_blank;
                pend_valid <= 1'b0;
            end
            // A load on the wrap edge refills pending after the old contents moved out.
            if (load) begin
                pend_val   <= value;
                pend_dp    <= dp_in;
                pend_blank <= blank_mask;
                pend_valid <= 1'b1;
            end

            if (in_guard) begin
                anode_n <= '1;
                display <= SEG_BLANK;
                dp_n    <= 1'b1;
            end else begin
                anode_n <= ~sel;
                display <= dig_blank ? SEG_BLANK : seg;
                dp_n    <= ~dig_dp;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: table of load vectors with expected frames fed
// through a queue, plus hand-built wrap, double-load, reset and LZB=0 sequences.
module tb_seg7_scan_driver;

    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] Z0 = 7'b1000000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_mask = '0;

    logic [0:6]  display, display_nz;
    logic        dp_n, dp_n_nz;
    logic [3:0]  anode_n, anode_n_nz;
    logic        frame_done, frame_done_nz;

    always #5 clk = ~clk;

    seg7_scan_driver #(.NUM_DIGITS(4), .DIV(4), .GUARD(1), .LZB(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .load       (load),
        .dp_in      (dp_in),
        .blank_mask (blank_mask),
        .display    (display),
        .dp_n       (dp_n),
        .anode_n    (anode_n),
        .frame_done (frame_done)
    );

    seg7_scan_driver #(.NUM_DIGITS(4), .DIV(4), .GUARD(1), .LZB(0)) dut_nz (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .load       (load),
        .dp_in      (dp_in),
        .blank_mask (blank_mask),
        .display    (display_nz),
        .dp_n       (dp_n_nz),
        .anode_n    (anode_n_nz),
        .frame_done (frame_done_nz)
    );

    typedef struct packed {
        logic [15:0]     value;
        logic [3:0]      dp;
        logic [3:0]      mask;
        logic [3:0][6:0] seg;
    } vec_t;

    typedef struct packed {
        logic [3:0][6:0] seg;
        logic [3:0]      dp;
    } frm_t;

    vec_t vecs[6];
    frm_t exp_q[$];
    frm_t cur, z, allz, allz_m;
    int   tests = 0;
    int   fails = 0;

    function automatic frm_t frm_of(input vec_t v);
        frm_t f;
        f.seg = v.seg;
        f.dp  = v.dp;
        return f;
    endfunction

    // Walks one 16-cycle frame starting just after a frame_done sample.
    task automatic check_frame(input frm_t f, input bit nz, input string tag);
        logic [3:0] ea, ga;
        logic [6:0] es, gs;
        logic       ed, ef, gd, gf;
        int         d;
        for (int s = 0; s < 16; s++) begin
            @(negedge clk);
            d = s / 4;
            if (s % 4 == 0) begin
                ea = 4'b1111;
                es = BL;
                ed = 1'b1;
            end else begin
                ea = ~(4'b0001 << d);
                es = f.seg[d];
                ed = ~f.dp[d];
            end
            ef = (s == 15);
            ga = nz ? anode_n_nz : anode_n;
            gs = nz ? display_nz : display;
            gd = nz ? dp_n_nz : dp_n;
            gf = nz ? frame_done_nz : frame_done;
            tests++;
            if ({ga, gs, gd, gf} !== {ea, es, ed, ef}) begin
                fails++;
                $display("FAIL %s slot %0d: got anode_n=%b display=%b dp_n=%b frame_done=%b, want anode_n=%b display=%b dp_n=%b frame_done=%b",
                         tag, s, ga, gs, gd, gf, ea, es, ed, ef);
            end
        end
    endtask

    task automatic load_at(input int delay_cyc, input vec_t v);
        repeat (delay_cyc) @(negedge clk);
        value      = v.value;
        dp_in      = v.dp;
        blank_mask = v.mask;
        load       = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{value: 16'h12AF, dp: 4'b0100, mask: 4'b0000,
                    seg: {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}};
        vecs[1] = '{value: 16'h0007, dp: 4'b0000, mask: 4'b0000,
                    seg: {BL, BL, BL, 7'b1111000}};
        vecs[2] = '{value: 16'h0000, dp: 4'b0000, mask: 4'b0000,
                    seg: {BL, BL, BL, 7'b1000000}};
        vecs[3] = '{value: 16'h8BC3, dp: 4'b1001, mask: 4'b0010,
                    seg: {7'b0000000, 7'b0000011, BL, 7'b0110000}};
        vecs[4] = '{value: 16'h0D05, dp: 4'b0010, mask: 4'b0000,
                    seg: {BL, 7'b0100001, 7'b1000000, 7'b0010010}};
        vecs[5] = '{value: 16'h9E46, dp: 4'b0000, mask: 4'b0000,
                    seg: {7'b0010000, 7'b0000110, 7'b0011001, 7'b0000010}};

        z      = '{seg: {BL, BL, BL, Z0}, dp: 4'b0000};
        allz   = '{seg: {Z0, Z0, Z0, Z0}, dp: 4'b0000};
        allz_m = '{seg: {BL, Z0, Z0, Z0}, dp: 4'b0000};

        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        fork
            check_frame(z, 1'b0, "reset_frame");
            check_frame(allz, 1'b1, "reset_frame_nolzb");
        join

        // Each load must not disturb the frame in progress; it shows one frame later.
        cur = z;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(frm_of(vecs[i]));
            fork
                load_at(0, vecs[i]);
                check_frame(cur, 1'b0, "vec_hold");
            join
            cur = exp_q.pop_front();
        end

        // Two loads in one frame: the later one wins.
        fork
            check_frame(cur, 1'b0, "dbl_hold");
            begin
                exp_q.push_back(frm_of(vecs[0]));
                load_at(5, vecs[0]);
                void'(exp_q.pop_back());
                exp_q.push_back(frm_of(vecs[1]));
                load_at(1, vecs[1]);
            end
        join
        cur = exp_q.pop_front();

        // Second load lands exactly on the wrap edge.
        exp_q.push_back(frm_of(vecs[3]));
        exp_q.push_back(frm_of(vecs[4]));
        fork
            load_at(0, vecs[3]);
            load_at(15, vecs[4]);
            check_frame(cur, 1'b0, "wrap_hold");
        join
        cur = exp_q.pop_front();
        check_frame(cur, 1'b0, "wrap_old");
        cur = exp_q.pop_front();
        check_frame(cur, 1'b0, "wrap_new");

        // Reset mid-slot with data pending.
        load_at(0, vecs[5]);
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        tests++;
        if ({anode_n, display, dp_n, frame_done, anode_n_nz, display_nz, dp_n_nz, frame_done_nz} !==
            {4'b1111, BL, 1'b1, 1'b0, 4'b1111, BL, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL async_reset: got anode_n=%b display=%b dp_n=%b frame_done=%b (nolzb %b %b %b %b), want 1111 1111111 1 0",
                     anode_n, display, dp_n, frame_done, anode_n_nz, display_nz, dp_n_nz, frame_done_nz);
        end
        @(negedge clk);
        reset = 1'b0;
        fork
            check_frame(z, 1'b0, "post_reset");
            check_frame(allz, 1'b1, "post_reset_nolzb");
        join
        fork
            load_at(0, '{value: 16'h0000, dp: 4'b0000, mask: 4'b1000, seg: '0});
            check_frame(z, 1'b0, "pend_discarded");
            check_frame(allz, 1'b1, "nolzb_zero");
        join
        fork
            check_frame(z, 1'b0, "mask_lzb");
            check_frame(allz_m, 1'b1, "nolzb_mask");
        join

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
